// File: rtl/spike_pkg.sv
// Shared defaults, FSM state encoding and saturating-increment helper for the spike rate decoder.
package spike_pkg;

    localparam int DEF_LANES    = 4;
    localparam int DEF_CNT_W    = 4;
    localparam int DEF_WIN_LOG2 = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    // Adds inc to val but never moves past max.
    function automatic logic [31:0] sat_inc(input logic [31:0] val,
                                            input logic        inc,
                                            input logic [31:0] max);
        return (inc && (val != max)) ? val + 32'd1 : val;
    endfunction

endpackage

// File: rtl/spike_lane_counter.sv
// One lane: rising-edge detect plus saturating counter; count already includes this cycle's edge.
// Edge history updates every cycle regardless of count_en, so a level held across windows counts once.
module spike_lane_counter
    import spike_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             spike,
    input  logic             count_en,
    input  logic             clear,
    output logic [CNT_W-1:0] count
);

    localparam logic [31:0] CNT_MAX = (32'd1 << CNT_W) - 32'd1;

    logic             prev;
    logic             rise;
    logic [CNT_W-1:0] acc;

    assign rise = spike & ~prev;

    always_comb begin
        count = acc;
        if (count_en) begin
            count = CNT_W'(sat_inc(32'(acc), rise, CNT_MAX));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev <= 1'b0;
            acc  <= '0;
        end else begin
            prev <= spike;
            acc  <= clear ? '0 : count;
        end
    end

endmodule

// File: rtl/spike_rate_decoder.sv
// Counts per-lane spike rising edges over 2^WIN_LOG2-cycle windows; result lands in rate one cycle after window end.
// Valid/ready output: an unaccepted result is overwritten by the next window and flags sticky overrun.
module spike_rate_decoder
    import spike_pkg::*;
#(
    parameter int LANES    = DEF_LANES,
    parameter int CNT_W    = DEF_CNT_W,
    parameter int WIN_LOG2 = DEF_WIN_LOG2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [LANES-1:0]       spike,
    output logic [LANES*CNT_W-1:0] rate,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   overrun,
    output logic                   busy
);

    localparam logic [WIN_LOG2-1:0] WIN_LAST = '1;

    state_t                 state;
    state_t                 state_nxt;
    logic [WIN_LOG2-1:0]    win_cnt;
    logic                   count_en;
    logic                   win_end;
    logic                   lane_clear;
    logic                   accept;
    logic [LANES*CNT_W-1:0] lane_cnt;

    assign count_en   = (state == COUNT) && en;
    assign win_end    = count_en && (win_cnt == WIN_LAST);
    // Dropping en mid-window discards the partial counts along with the window position.
    assign lane_clear = !count_en || win_end;
    assign accept     = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if ((state == IDLE) && en) begin
            state_nxt = COUNT;
        end else if ((state == COUNT) && !en) begin
            state_nxt = IDLE;
        end
    end

    always_comb begin
        busy = (state == COUNT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            win_cnt <= '0;
        end else if (count_en) begin
            win_cnt <= win_cnt + WIN_LOG2'(1);
        end else begin
            win_cnt <= '0;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        spike_lane_counter #(
            .CNT_W (CNT_W)
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .spike    (spike[i]),
            .count_en (count_en),
            .clear    (lane_clear),
            .count    (lane_cnt[i*CNT_W +: CNT_W])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rate      <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (win_end) begin
                rate <= lane_cnt;
            end
            if (win_end) begin
                out_valid <= 1'b1;
            end else if (accept) begin
                out_valid <= 1'b0;
            end
            if (win_end && out_valid && !out_ready) begin
                overrun <= 1'b1;
            end else if (accept) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Directed scoreboard bench: a 16-cycle-window decoder plus a 32-cycle-window one for saturation.
module tb_spike_rate_decoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [3:0]  spike = 4'b0;
    logic [15:0] rate;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        overrun;
    logic        busy;

    logic        b_en = 1'b0;
    logic [3:0]  b_spike = 4'b0;
    logic [15:0] b_rate;
    logic        b_valid;
    logic        b_ready = 1'b0;
    logic        b_overrun;
    logic        b_busy;

    typedef struct packed {
        logic [15:0] rate;
        logic        ovr;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea;
    exp_t eb;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    spike_rate_decoder #(.LANES(4), .CNT_W(4), .WIN_LOG2(4)) dut_a (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .spike     (spike),
        .rate      (rate),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overrun   (overrun),
        .busy      (busy)
    );

    spike_rate_decoder #(.LANES(4), .CNT_W(4), .WIN_LOG2(5)) dut_b (
        .clk       (clk),
        .rst       (rst),
        .en        (b_en),
        .spike     (b_spike),
        .rate      (b_rate),
        .out_valid (b_valid),
        .out_ready (b_ready),
        .overrun   (b_overrun),
        .busy      (b_busy)
    );

    function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endfunction

    // Each accepted result is compared against the oldest expected result for that instance.
    always @(negedge clk) begin
        if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (qa.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL a_unexpected: got rate %0h, expected no result", rate);
            end else begin
                ea = qa.pop_front();
                check("a_rate", 32'(rate), 32'(ea.rate));
                check("a_overrun", 32'(overrun), 32'(ea.ovr));
            end
        end
    end

    always @(negedge clk) begin
        if (rst === 1'b0 && b_valid === 1'b1 && b_ready === 1'b1) begin
            if (qb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL b_unexpected: got rate %0h, expected no result", b_rate);
            end else begin
                eb = qb.pop_front();
                check("b_rate", 32'(b_rate), 32'(eb.rate));
                check("b_overrun", 32'(b_overrun), 32'(eb.ovr));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // From IDLE: one cycle with en=1 moves to COUNT; the next cycle is window cycle 0.
    task automatic start();
        en    = 1'b1;
        spike = 4'b0;
        step();
    endtask

    task automatic stop();
        en    = 1'b0;
        spike = 4'b0;
        step();
    endtask

    // Bit k of each argument is that lane's level (or out_ready) during window cycle k.
    task automatic window(input logic [15:0] l0, input logic [15:0] l1,
                          input logic [15:0] l2, input logic [15:0] l3,
                          input logic [15:0] r);
        for (int k = 0; k < 16; k++) begin
            spike     = {l3[k], l2[k], l1[k], l0[k]};
            out_ready = r[k];
            step();
        end
    endtask

    initial begin
        // Reset with noisy inputs
        rst       = 1'b1;
        en        = 1'($urandom);
        spike     = 4'($urandom);
        out_ready = 1'($urandom);
        b_en      = 1'($urandom);
        b_spike   = 4'($urandom);
        step();
        spike     = 4'($urandom);
        b_spike   = 4'($urandom);
        step();
        rst       = 1'b0;
        en        = 1'b0;
        spike     = 4'b0;
        out_ready = 1'b0;
        b_en      = 1'b0;
        b_spike   = 4'b0;
        b_ready   = 1'b1;
        check("rst_rate", 32'(rate), 32'h0);
        check("rst_valid", 32'(out_valid), 32'h0);
        check("rst_overrun", 32'(overrun), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_b_valid", 32'(b_valid), 32'h0);
        check("rst_b_busy", 32'(b_busy), 32'h0);
        step();

        // Lane0 held high cycles 2-6 (one rise), lane1 toggles (8 rises)
        out_ready = 1'b1;
        start();
        check("t2_busy", 32'(busy), 32'h1);
        qa.push_back('{rate: 16'h0081, ovr: 1'b0});
        window(16'h007C, 16'h5555, 16'h0000, 16'h0000, 16'hFFFF);
        check("t2_valid", 32'(out_valid), 32'h1);
        stop();
        check("t2_accepted", 32'(out_valid), 32'h0);
        check("t2_idle", 32'(busy), 32'h0);
        step();

        // Two windows with no consumer: second overwrites the first
        out_ready = 1'b0;
        start();
        qa.push_back('{rate: 16'h0005, ovr: 1'b1});
        window(16'h0015, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        check("t4_rate1", 32'(rate), 32'h0003);
        check("t4_valid1", 32'(out_valid), 32'h1);
        check("t4_ovr1", 32'(overrun), 32'h0);
        window(16'h0155, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        check("t4_rate2", 32'(rate), 32'h0005);
        check("t4_ovr2", 32'(overrun), 32'h1);
        check("t4_valid2", 32'(out_valid), 32'h1);
        stop();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("t4_valid_clr", 32'(out_valid), 32'h0);
        check("t4_ovr_clr", 32'(overrun), 32'h0);

        // Abort at window cycle 7 after 4 rises on lane3, then a clean window
        out_ready = 1'b1;
        start();
        for (int k = 0; k < 7; k++) begin
            spike = (k % 2 == 0) ? 4'b1000 : 4'b0000;
            step();
        end
        stop();
        repeat (12) step();
        check("t5_no_valid", 32'(out_valid), 32'h0);
        check("t5_idle", 32'(busy), 32'h0);
        start();
        qa.push_back('{rate: 16'h2000, ovr: 1'b0});
        window(16'h0000, 16'h0000, 16'h0000, 16'h0005, 16'hFFFF);
        stop();

        // Accept lands on the window-end cycle of the next result
        out_ready = 1'b0;
        start();
        qa.push_back('{rate: 16'h0100, ovr: 1'b0});
        window(16'h0000, 16'h0000, 16'h0008, 16'h0000, 16'h0000);
        qa.push_back('{rate: 16'h0201, ovr: 1'b0});
        window(16'h0400, 16'h0000, 16'h0022, 16'h0000, 16'h8000);
        out_ready = 1'b0;
        check("t6_valid", 32'(out_valid), 32'h1);
        check("t6_ovr", 32'(overrun), 32'h0);
        check("t6_rate", 32'(rate), 32'h0201);
        stop();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("t6_valid_clr", 32'(out_valid), 32'h0);

        // 32-cycle window, lane2 toggles: 16 rises must saturate at 15
        b_ready = 1'b1;
        b_en    = 1'b1;
        step();
        qb.push_back('{rate: 16'h0F00, ovr: 1'b0});
        for (int k = 0; k < 32; k++) begin
            b_spike = (k % 2 == 0) ? 4'b0100 : 4'b0000;
            step();
        end
        check("t3_valid", 32'(b_valid), 32'h1);
        check("t3_rate", 32'(b_rate), 32'h0F00);
        b_en    = 1'b0;
        b_spike = 4'b0;
        step();
        step();

        check("qa_drained", 32'(qa.size()), 32'h0);
        check("qb_drained", 32'(qb.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
